// File: rtl/keypad_pkg.sv
// Shared key-code constants, debounce state type and key classification helpers
// for the keypad entry controller.
package keypad_pkg;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'd13;

  typedef enum logic [1:0] {
    DEB_IDLE    = 2'd0,
    DEB_PRESS   = 2'd1,
    DEB_HELD    = 2'd2,
    DEB_RELEASE = 2'd3
  } deb_state_e;

  // Codes 12, 14 and 15 are not real keys and behave exactly like KEY_NONE.
  function automatic logic is_no_key(input logic [3:0] code);
    return code > KEY_HASH;
  endfunction

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Keypad debounce FSM: turns a bouncing scanner code into one event per press.
//
// state       | meaning
// DEB_IDLE    | no key down, waiting for any key code
// DEB_PRESS   | candidate code captured, counting stable cycles
// DEB_HELD    | press accepted, waiting for the first no-key cycle
// DEB_RELEASE | counting stable no-key cycles; a key bounce goes back to HELD
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] keyCode,
  output logic       keyEvent,
  output logic [3:0] keyLast
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  deb_state_e      state_q, state_d;
  logic [3:0]      code_q, code_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            event_q, event_d;
  logic [3:0]      last_q, last_d;
  logic            no_key;

  assign no_key   = is_no_key(keyCode);
  assign keyEvent = event_q;
  assign keyLast  = last_q;

  // Next-state logic; the counter terminates at DEBOUNCE_CYCLES-1 after the capture cycle.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    event_d = 1'b0;
    last_d  = last_q;
    case (state_q)
      DEB_IDLE: begin
        if (!no_key) begin
          state_d = DEB_PRESS;
          code_d  = keyCode;
          cnt_d   = '0;
        end
      end
      DEB_PRESS: begin
        if (no_key) begin
          state_d = DEB_IDLE;
          cnt_d   = '0;
        end else if (keyCode != code_q) begin
          code_d = keyCode;
          cnt_d  = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d = DEB_HELD;
          event_d = 1'b1;
          last_d  = code_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DEB_HELD: begin
        if (no_key) begin
          state_d = DEB_RELEASE;
          cnt_d   = '0;
        end
      end
      DEB_RELEASE: begin
        if (!no_key) begin
          state_d = DEB_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d = DEB_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = DEB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DEB_IDLE;
      code_q  <= KEY_NONE;
      cnt_q   <= '0;
      event_q <= 1'b0;
      last_q  <= KEY_NONE;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      event_q <= event_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounced keys build a decimal value, '#' presents it,
// entryAck consumes it. Macro KEYPAD_BACKSPACE_EN makes '*' delete the last digit
// instead of clearing the whole entry. MAX_DIGITS must not exceed 9 so the value
// always fits in 32 bits.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_DIGITS      = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  keyCode,
  input  logic        entryAck,
  output logic [31:0] value,
  output logic [3:0]  digitCount,
  output logic        entryValid,
  output logic        keyEvent,
  output logic [3:0]  keyLast,
  output logic        full
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  logic        key_event;
  logic [3:0]  key_last;
  logic [31:0] value_q, value_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;

  keypad_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock   (clock),
    .reset   (reset),
    .keyCode (keyCode),
    .keyEvent(key_event),
    .keyLast (key_last)
  );

  assign keyEvent   = key_event;
  assign keyLast    = key_last;
  assign value      = value_q;
  assign digitCount = cnt_q;
  assign entryValid = valid_q;
  assign full       = (cnt_q == MAX_CNT);

  // Entry accumulator; an ack on a presented entry overrides a key accepted in the same cycle.
  always_comb begin
    value_d = value_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (valid_q && entryAck) begin
      value_d = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (key_event && !valid_q) begin
      if (is_digit(key_last)) begin
        if (cnt_q < MAX_CNT) begin
          value_d = value_q * 32'd10 + {28'd0, key_last};
          cnt_d   = cnt_q + 4'd1;
        end
      end else if (key_last == KEY_STAR) begin
`ifdef KEYPAD_BACKSPACE_EN
        if (cnt_q != 4'd0) begin
          value_d = value_q / 32'd10;
          cnt_d   = cnt_q - 4'd1;
        end
`else
        value_d = '0;
        cnt_d   = '0;
`endif
      end else if (key_last == KEY_HASH) begin
        if (cnt_q != 4'd0) begin
          valid_d = 1'b1;
        end
      end
    end
  end

  // Entry registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      value_q <= value_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: run-length key acceptance model plus a digit queue,
// compared every cycle, and literal checks at the scenario end points.
module tb_keypad_entry_ctrl;

  localparam int DEB  = 4;
  localparam int MAXD = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  keyCode;
  logic        entryAck;
  logic [31:0] value;
  logic [3:0]  digitCount;
  logic        entryValid;
  logic        keyEvent;
  logic [3:0]  keyLast;
  logic        full;

  int n_vec  = 0;
  int n_bad  = 0;
  int ev_cnt = 0;
  bit chk_en = 0;

  keypad_entry_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .MAX_DIGITS     (MAXD)
  ) dut (
    .clock     (clk),
    .reset     (reset),
    .keyCode   (keyCode),
    .entryAck  (entryAck),
    .value     (value),
    .digitCount(digitCount),
    .entryValid(entryValid),
    .keyEvent  (keyEvent),
    .keyLast   (keyLast),
    .full      (full)
  );

  always #5 clk = ~clk;

  // Model state: a key is accepted once DEB+1 identical key samples arrive in a row,
  // and released once DEB+1 no-key samples arrive in a row.
  int unsigned m_q[$];
  bit          m_valid   = 0;
  bit          m_event   = 0;
  bit          m_pressed = 0;
  int          m_run     = 0;
  logic [3:0]  m_code    = 4'd13;
  logic [3:0]  m_last    = 4'd13;

  function automatic logic [31:0] m_value();
    logic [31:0] v = 0;
    foreach (m_q[i]) v = v * 10 + m_q[i];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge from the inputs applied during that cycle.
  always @(posedge clk) begin
    bit nk;
    if (reset) begin
      m_q.delete();
      m_valid = 0; m_event = 0; m_pressed = 0; m_run = 0; m_last = 4'd13;
    end else begin
      if (m_valid && entryAck) begin
        m_q.delete();
        m_valid = 0;
      end else if (m_event && !m_valid) begin
        if (m_last <= 9) begin
          if (m_q.size() < MAXD) m_q.push_back(m_last);
        end else if (m_last == 10) begin
`ifdef KEYPAD_BACKSPACE_EN
          if (m_q.size() > 0) void'(m_q.pop_back());
`else
          m_q.delete();
`endif
        end else if (m_last == 11) begin
          if (m_q.size() > 0) m_valid = 1;
        end
      end
      m_event = 0;
      nk = (keyCode > 11);
      if (!m_pressed) begin
        if (nk) m_run = 0;
        else if (m_run > 0 && keyCode == m_code) m_run++;
        else begin m_code = keyCode; m_run = 1; end
        if (m_run == DEB + 1) begin
          m_pressed = 1; m_event = 1; m_last = m_code; m_run = 0;
        end
      end else begin
        if (nk) m_run++;
        else m_run = 0;
        if (m_run == DEB + 1) begin m_pressed = 0; m_run = 0; end
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("keyEvent",   {31'd0, keyEvent},   {31'd0, m_event});
      chk("keyLast",    {28'd0, keyLast},    {28'd0, m_last});
      chk("value",      value,               m_value());
      chk("digitCount", {28'd0, digitCount}, 32'(m_q.size()));
      chk("entryValid", {31'd0, entryValid}, {31'd0, m_valid});
      chk("full",       {31'd0, full},       {31'd0, (m_q.size() == MAXD)});
      if (keyEvent === 1'b1) ev_cnt++;
    end
  end

  task automatic key(input logic [3:0] c, input int n);
    keyCode = c;
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] c);
    key(c, 6);
    key(4'd13, 6);
  endtask

  task automatic ack_pulse();
    entryAck = 1'b1;
    @(negedge clk);
    entryAck = 1'b0;
  endtask

  initial begin
    int e0;
    keyCode  = 4'd13;
    entryAck = 1'b0;
    reset    = 1'b1;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1;
    chk("rst_keyLast", {28'd0, keyLast}, 32'd13);
    chk("rst_value", value, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);

    // Short press rejected, long press accepted once.
    e0 = ev_cnt;
    key(4'd7, 3);
    key(4'd13, 6);
    chk("short_press_events", 32'(ev_cnt - e0), 32'd0);
    key(4'd7, 6);
    key(4'd13, 6);
    chk("long_press_events", 32'(ev_cnt - e0), 32'd1);
    chk("long_press_keyLast", {28'd0, keyLast}, 32'd7);
    press(4'd10);
    chk("star_clears_7", value, 32'd0);

    // 1,2,3,# then acknowledge.
    press(4'd1); press(4'd2); press(4'd3); press(4'd11);
    chk("e123_value", value, 32'd123);
    chk("e123_count", {28'd0, digitCount}, 32'd3);
    chk("e123_valid", {31'd0, entryValid}, 32'd1);
    ack_pulse();
    chk("ack_value", value, 32'd0);
    chk("ack_count", {28'd0, digitCount}, 32'd0);
    chk("ack_valid", {31'd0, entryValid}, 32'd0);

    // Nine 9s: the ninth is dropped.
    repeat (9) press(4'd9);
    chk("nines_value", value, 32'd99999999);
    chk("nines_count", {28'd0, digitCount}, 32'd8);
    chk("nines_full", {31'd0, full}, 32'd1);
    press(4'd11);
    ack_pulse();
    chk("nines_cleared", value, 32'd0);

    // Release bounce yields a single event.
    e0 = ev_cnt;
    key(4'd4, 6); key(4'd13, 2); key(4'd4, 1); key(4'd13, 6);
    chk("bounce_events", 32'(ev_cnt - e0), 32'd1);
    chk("bounce_value", value, 32'd4);
    press(4'd10);

    // 5,6 then '*'.
    press(4'd5); press(4'd6); press(4'd10);
`ifdef KEYPAD_BACKSPACE_EN
    chk("star_value", value, 32'd5);
    chk("star_count", {28'd0, digitCount}, 32'd1);
`else
    chk("star_value", value, 32'd0);
    chk("star_count", {28'd0, digitCount}, 32'd0);
`endif
    press(4'd10);

    // '#' on an empty entry is ignored.
    press(4'd11);
    chk("empty_hash_valid", {31'd0, entryValid}, 32'd0);

    // Ack without a presented entry has no effect.
    press(4'd8);
    ack_pulse();
    chk("idle_ack_value", value, 32'd8);
    press(4'd10);

    // Keys are ignored while an entry is presented; ack beats a simultaneous key.
    press(4'd1); press(4'd11); press(4'd2);
    chk("frozen_value", value, 32'd1);
    chk("frozen_valid", {31'd0, entryValid}, 32'd1);
    key(4'd5, 5);
    chk("collide_event", {31'd0, keyEvent}, 32'd1);
    ack_pulse();
    key(4'd13, 6);
    chk("collide_value", value, 32'd0);
    chk("collide_count", {28'd0, digitCount}, 32'd0);
    chk("collide_keyLast", {28'd0, keyLast}, 32'd5);

    // Reset in the middle of a press abandons it.
    press(4'd2);
    chk("pre_reset_value", value, 32'd2);
    e0 = ev_cnt;
    key(4'd3, 2);
    reset   = 1'b1;
    keyCode = 4'd13;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("reset_events", 32'(ev_cnt - e0), 32'd0);
    chk("reset_value", value, 32'd0);
    chk("reset_keyLast", {28'd0, keyLast}, 32'd13);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles needed to accept a press or a release.
- MAX_DIGITS, 8, maximum decimal digits held in one entry.
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- clock, in, 1, single system clock.
- reset, in, 1, synchronous, active-high.
- keyCode, in, 4, raw scanner code: 0-9 digits, 10 '*', 11 '#', 13 no key; other values are treated as no key.
- entryAck, in, 1, consumer accepts the presented entry.
- value, out, 32, binary value of the digits entered.
- digitCount, out, 4, number of digits held.
- entryValid, out, 1, a completed entry is presented.
- keyEvent, out, 1, one-cycle pulse per accepted key.
- keyLast, out, 4, code of the most recently accepted key.
- full, out, 1, digitCount equals MAX_DIGITS.
REQ-003 SHALL use one clock (clock); reset is synchronous and active-high (reset).

Function
REQ-004 SHALL run a debounce FSM with states IDLE, PRESS, HELD and RELEASE.
- IDLE -> PRESS: keyCode is not no-key; capture the code and clear the counter.
- PRESS -> HELD: the captured code is held for DEBOUNCE_CYCLES consecutive cycles.
- In PRESS, a different code restarts the counter; a no-key code returns the FSM to IDLE.
REQ-005 SHALL assert keyEvent for exactly one cycle, and update keyLast, on the PRESS->HELD transition.
- Holding the key SHALL never generate a repeat event.
REQ-006 SHALL leave HELD for RELEASE on the first no-key cycle.
- In RELEASE, DEBOUNCE_CYCLES consecutive no-key cycles SHALL move the FSM to IDLE.
- In RELEASE, any key code SHALL return the FSM to HELD with no new event.
REQ-007 SHALL, on an accepted digit d while entryValid=0 and digitCount<MAX_DIGITS, perform next cycle:
- value <= value*10 + d.
- digitCount <= digitCount + 1.
REQ-008 SHALL ignore an accepted digit when digitCount==MAX_DIGITS; value and count are unchanged and full stays 1.
REQ-009 SHALL, on an accepted '*' while entryValid=0, clear value and digitCount to 0 (see REQ-015 for the alternative).
REQ-010 SHALL, on an accepted '#' with digitCount>0 and entryValid=0, set entryValid=1 on the next cycle.
- value and digitCount SHALL then stay frozen until acknowledged.
- A '#' with digitCount==0 SHALL be ignored; keyEvent still pulses.
REQ-011 SHALL ignore digit, '*' and '#' effects while entryValid=1; keyEvent still pulses.
REQ-012 SHALL, when entryAck=1 and entryValid=1 at a clock edge, set entryValid, value and digitCount to 0 on the next cycle.
- entryAck while entryValid=0 SHALL have no effect.
- A key accepted in the same cycle as an ack SHALL be discarded: ack wins.
REQ-013 SHALL keep the arithmetic unsigned; MAX_DIGITS<=9 guarantees no 32-bit overflow, and values with MAX_DIGITS>9 are illegal.

Reset
REQ-014 SHALL, on reset, load the following, abandoning any debounce or entry in progress:
- FSM = IDLE, counter = 0.
- value = 0, digitCount = 0.
- entryValid = 0, keyEvent = 0, full = 0, keyLast = 13.

Configuration
REQ-015 SHALL support macro KEYPAD_BACKSPACE_EN.
- Defined: '*' removes the last digit: value <= value/10 and digitCount <= digitCount-1; '*' with digitCount==0 is ignored.
- Undefined: '*' clears the whole entry as in REQ-009.

Structure
REQ-016 SHALL place the following in shared package keypad_pkg:
- Key-code constants KEY_STAR=10, KEY_HASH=11, KEY_NONE=13.
- The debounce state enum.
REQ-017 SHALL implement REQ-004..006 in sub-module keypad_debounce (outputs keyEvent, keyLast); the entry accumulator stays in the top level.

Verification (DEBOUNCE_CYCLES=4, MAX_DIGITS=8)
REQ-018 Press '7' for 3 cycles, release, then press '7' for 6 cycles -> no event on the first press, exactly one keyEvent on the second, keyLast=7.
REQ-019 Keys 1,2,3 then '#' -> value=123, digitCount=3, entryValid=1; entryAck for 1 cycle -> next cycle value=0, digitCount=0, entryValid=0.
REQ-020 Nine digits '9' -> value=99999999, digitCount=8, full=1; the ninth digit is ignored.
REQ-021 Key '4' held, release bouncing to no-key for 2 cycles, '4' for 1 cycle, then 5 no-key cycles -> exactly one event total.
REQ-022 Entries 5,6 then '*' -> value=0 without the macro; value=5, digitCount=1 with KEYPAD_BACKSPACE_EN.
REQ-023 '#' on an empty entry -> entryValid stays 0; reset asserted mid-PRESS -> FSM=IDLE, value=0, and no keyEvent follows.
